csr_trap_ctrl: RTL and testbench

// Sequences machine-mode interrupt entry and mret return around the CSR register file.
// - Owns and arbitrates the CSR file's single write port between pipeline CSR instructions and its own trap sequence.
// - Detects enabled pending interrupts and saves pc to mepc.
// - Updates mstatus MIE/MPIE, then redirects/flushes the pipeline to the trap vector or back to mepc.
// - Sits between decode/execute and csr_reg.

---
 rtl/csr_pkg.sv | 30 +++
 rtl/csr_trap_ctrl_if.sv | 20 ++
 rtl/csr_trap_ctrl_irq_prio.sv | 24 ++
 rtl/csr_trap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, bit positions, interrupt causes and the trap sequencer state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SET_STATUS,
    ST_TRAP_REDIR,
    ST_MRET_RESTORE,
    ST_MRET_REDIR
  } trap_state_e;

  function automatic logic [31:0] csr_addr32(input logic [11:0] a);
    return {20'h0, a};
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// CSR file write port plus the read taps the trap sequencer needs.
// Handshake: csr_wr is a single-cycle write strobe; the CSR file always accepts it (no ready).
interface csr_trap_ctrl_if;
  logic        csr_wr;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mepc_q;

  modport master (
    output csr_wr, csr_addr, csr_wdata,
    input  mstatus_q, mie_q, mepc_q
  );

  modport slave (
    input  csr_wr, csr_addr, csr_wdata,
    output mstatus_q, mie_q, mepc_q
  );
endinterface

// File: rtl/csr_trap_ctrl_irq_prio.sv
// Qualifies pending interrupts against global/individual enables; external beats timer.
module irq_prio
  import csr_pkg::*;
(
  input  logic        inst_valid,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        mstatus_mie,
  input  logic [31:0] mie_q,
  output logic        take,
  output logic [31:0] cause
);

  logic ext_en;
  logic tmr_en;
  logic unused_mie;

  assign unused_mie = ^{mie_q[31:12], mie_q[10:8], mie_q[6:0]};
  assign ext_en     = mie_q[MIE_MEIE] & ext_irq;
  assign tmr_en     = mie_q[MIE_MTIE] & timer_irq;
  assign take       = inst_valid & mstatus_mie & (ext_en | tmr_en);
  assign cause      = ext_en ? CAUSE_M_EXT : CAUSE_M_TIMER;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode interrupt entry / mret sequencer; owns the CSR file write port.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_ADDR = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_irq,
  input  logic                   timer_irq,
  input  logic                   inst_valid,
  input  logic                   is_mret,
  input  logic [31:0]            pc_in,
  input  logic                   pipe_csr_wr,
  input  logic [31:0]            pipe_csr_addr,
  input  logic [31:0]            pipe_csr_wdata,
  csr_trap_ctrl_if.master        csr_bus,
  output logic                   pipe_stall,
  output logic                   flush,
  output logic                   pc_redirect,
  output logic [31:0]            redirect_pc,
  output logic [31:0]            trap_cause,
  output logic                   trap_active,
  output trap_state_e            dbg_state
);

  trap_state_e state_q, state_d;
  logic [31:0] pc_snap_q, pc_snap_d;
  logic [31:0] status_snap_q, status_snap_d;
  logic [31:0] mepc_snap_q, mepc_snap_d;
  logic [31:0] cause_snap_q, cause_snap_d;
  logic [31:0] trap_cause_q, trap_cause_d;

  logic        take;
  logic [31:0] cause;
  logic [31:0] status_trap;
  logic [31:0] status_mret;

  irq_prio u_irq_prio (
    .inst_valid  (inst_valid),
    .ext_irq     (ext_irq),
    .timer_irq   (timer_irq),
    .mstatus_mie (csr_bus.mstatus_q[MSTATUS_MIE]),
    .mie_q       (csr_bus.mie_q),
    .take        (take),
    .cause       (cause)
  );

  always_comb begin
    status_trap               = status_snap_q;
    status_trap[MSTATUS_MPIE] = status_snap_q[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]  = 1'b0;
    status_mret               = status_snap_q;
    status_mret[MSTATUS_MIE]  = status_snap_q[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE] = 1'b1;
  end

  always_comb begin
    state_d             = state_q;
    pc_snap_d           = pc_snap_q;
    status_snap_d       = status_snap_q;
    mepc_snap_d         = mepc_snap_q;
    cause_snap_d        = cause_snap_q;
    trap_cause_d        = trap_cause_q;
    csr_bus.csr_wr      = 1'b0;
    csr_bus.csr_addr    = '0;
    csr_bus.csr_wdata   = '0;
    pipe_stall          = 1'b1;
    flush               = 1'b0;
    pc_redirect         = 1'b0;
    redirect_pc         = '0;

    case (state_q)
      ST_IDLE: begin
        pipe_stall = 1'b0;
        // Interrupt beats both mret and a same-cycle pipeline write, which is dropped.
        if (take) begin
          pipe_stall    = 1'b1;
          pc_snap_d     = pc_in;
          status_snap_d = csr_bus.mstatus_q;
          cause_snap_d  = cause;
          state_d       = ST_SAVE_EPC;
        end else if (inst_valid && is_mret) begin
          pipe_stall    = 1'b1;
          status_snap_d = csr_bus.mstatus_q;
          mepc_snap_d   = csr_bus.mepc_q;
          state_d       = ST_MRET_RESTORE;
        end else begin
          csr_bus.csr_wr    = pipe_csr_wr;
          csr_bus.csr_addr  = pipe_csr_addr;
          csr_bus.csr_wdata = pipe_csr_wdata;
        end
      end
      ST_SAVE_EPC: begin
        csr_bus.csr_wr    = 1'b1;
        csr_bus.csr_addr  = csr_addr32(CSR_MEPC);
        csr_bus.csr_wdata = pc_snap_q;
        state_d           = ST_SET_STATUS;
      end
      ST_SET_STATUS: begin
        csr_bus.csr_wr    = 1'b1;
        csr_bus.csr_addr  = csr_addr32(CSR_MSTATUS);
        csr_bus.csr_wdata = status_trap;
        trap_cause_d      = cause_snap_q;
        state_d           = ST_TRAP_REDIR;
      end
      ST_TRAP_REDIR: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        redirect_pc = MTVEC_ADDR;
        state_d     = ST_IDLE;
      end
      ST_MRET_RESTORE: begin
        csr_bus.csr_wr    = 1'b1;
        csr_bus.csr_addr  = csr_addr32(CSR_MSTATUS);
        csr_bus.csr_wdata = status_mret;
        state_d           = ST_MRET_REDIR;
      end
      ST_MRET_REDIR: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        redirect_pc = mepc_snap_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs read zero while reset is held, even with live pipeline requests.
    if (rst) begin
      csr_bus.csr_wr    = 1'b0;
      csr_bus.csr_addr  = '0;
      csr_bus.csr_wdata = '0;
      pipe_stall        = 1'b0;
      flush             = 1'b0;
      pc_redirect       = 1'b0;
      redirect_pc       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_snap_q     <= '0;
      status_snap_q <= '0;
      mepc_snap_q   <= '0;
      cause_snap_q  <= '0;
      trap_cause_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_snap_q     <= pc_snap_d;
      status_snap_q <= status_snap_d;
      mepc_snap_q   <= mepc_snap_d;
      cause_snap_q  <= cause_snap_d;
      trap_cause_q  <= trap_cause_d;
    end
  end

  assign trap_cause  = trap_cause_q;
  assign trap_active = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: small CSR file model, write/redirect scoreboards, vector table.
module tb_csr_trap_ctrl;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq, timer_irq, inst_valid, is_mret;
  logic [31:0] pc_in;
  logic        pipe_csr_wr;
  logic [31:0] pipe_csr_addr, pipe_csr_wdata;
  logic        pipe_stall, flush, pc_redirect, trap_active;
  logic [31:0] redirect_pc, trap_cause;
  trap_state_e dbg_state;

  logic [31:0] m_mstatus = 32'h0;
  logic [31:0] m_mie     = 32'h0;
  logic [31:0] m_mepc    = 32'h0;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] redir_q[$];

  csr_trap_ctrl_if csr_bus ();

  assign csr_bus.mstatus_q = m_mstatus;
  assign csr_bus.mie_q     = m_mie;
  assign csr_bus.mepc_q    = m_mepc;

  csr_trap_ctrl #(.MTVEC_ADDR(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .ext_irq        (ext_irq),
    .timer_irq      (timer_irq),
    .inst_valid     (inst_valid),
    .is_mret        (is_mret),
    .pc_in          (pc_in),
    .pipe_csr_wr    (pipe_csr_wr),
    .pipe_csr_addr  (pipe_csr_addr),
    .pipe_csr_wdata (pipe_csr_wdata),
    .csr_bus        (csr_bus.master),
    .pipe_stall     (pipe_stall),
    .flush          (flush),
    .pc_redirect    (pc_redirect),
    .redirect_pc    (redirect_pc),
    .trap_cause     (trap_cause),
    .trap_active    (trap_active),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // CSR file model: stores what the controller writes.
  always @(posedge clk) begin
    if (csr_bus.csr_wr) begin
      case (csr_bus.csr_addr)
        32'h300: m_mstatus <= csr_bus.csr_wdata;
        32'h304: m_mie     <= csr_bus.csr_wdata;
        32'h341: m_mepc    <= csr_bus.csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every CSR write and redirect must match the next expected entry.
  always @(negedge clk) begin
    if (csr_bus.csr_wr) begin
      if (exp_q.size() == 0) chk("unexpected_csr_wr", {csr_bus.csr_addr, csr_bus.csr_wdata}, 64'h0);
      else chk("csr_wr", {csr_bus.csr_addr, csr_bus.csr_wdata}, exp_q.pop_front());
    end
    if (pc_redirect) begin
      chk("redirect_flush", flush, 1'b1);
      if (redir_q.size() == 0) chk("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
      else chk("redirect_pc", redirect_pc, redir_q.pop_front());
    end
  end

  // Driver tasks
  task automatic clear_inputs();
    ext_irq = 0; timer_irq = 0; inst_valid = 0; is_mret = 0; pc_in = 0;
    pipe_csr_wr = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0;
  endtask

  task automatic pipe_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    pipe_csr_wr = 1; pipe_csr_addr = addr; pipe_csr_wdata = data;
    exp_q.push_back({addr, data});
    @(negedge clk);
    chk("pass_csr_wr", csr_bus.csr_wr, 1'b1);
    chk("pass_stall", pipe_stall, 1'b0);
    @(posedge clk); #1;
    pipe_csr_wr = 0;
  endtask

  task automatic run_trap(input logic [31:0] pc, input logic ext, input logic tim,
                          input logic [31:0] exp_ms, input logic [31:0] exp_cause,
                          input logic with_pipe, input logic with_mret);
    @(posedge clk); #1;
    inst_valid = 1; pc_in = pc; ext_irq = ext; timer_irq = tim; is_mret = with_mret;
    if (with_pipe) begin
      pipe_csr_wr = 1; pipe_csr_addr = 32'h304; pipe_csr_wdata = 32'h880;
    end
    exp_q.push_back({32'h341, pc});
    exp_q.push_back({32'h300, exp_ms});
    redir_q.push_back(32'h100);
    @(negedge clk);
    chk("detect_stall", pipe_stall, 1'b1);
    chk("detect_no_wr", csr_bus.csr_wr, 1'b0);
    @(posedge clk); #1;
    // Irq lines change after detect; cause must stay latched.
    inst_valid = 0; is_mret = 0; ext_irq = 0; timer_irq = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("trap_stall_k%0d", k), pipe_stall, (k < 4));
      chk($sformatf("trap_active_k%0d", k), trap_active, (k < 4));
      chk($sformatf("trap_redir_k%0d", k), pc_redirect, (k == 3));
      @(posedge clk); #1;
      if (k == 3) clear_inputs();
    end
    chk("trap_cause", trap_cause, exp_cause);
    chk("trap_mepc", m_mepc, pc);
    chk("trap_mstatus", m_mstatus, exp_ms);
  endtask

  task automatic no_take(input logic ext, input logic tim, input string name);
    @(posedge clk); #1;
    inst_valid = 1; pc_in = 32'h200; ext_irq = ext; timer_irq = tim;
    @(negedge clk);
    chk({name, "_stall"}, pipe_stall, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk({name, "_idle"}, trap_active, 1'b0);
  endtask

  typedef struct {
    logic [31:0] ms;
    logic [31:0] mie;
    logic        ext;
    logic        tim;
    logic [31:0] pc;
    logic        take;
    logic [31:0] cause;
    logic [31:0] exp_ms;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h8,    32'h800, 1, 0, 32'h40, 1, 32'h8000_000B, 32'h80};
    vecs[1] = '{32'h0,    32'h880, 1, 1, 32'h50, 0, 32'h0,          32'h0};
    vecs[2] = '{32'h8,    32'h880, 1, 1, 32'h54, 1, 32'h8000_000B, 32'h80};
    vecs[3] = '{32'h8,    32'h080, 0, 1, 32'h58, 1, 32'h8000_0007, 32'h80};
    vecs[4] = '{32'h8,    32'h080, 1, 0, 32'h5C, 0, 32'h0,          32'h0};
    vecs[5] = '{32'h88,   32'h800, 1, 0, 32'h70, 1, 32'h8000_000B, 32'h80};
    vecs[6] = '{32'h1808, 32'h880, 0, 1, 32'h74, 1, 32'h8000_0007, 32'h1880};

    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {csr_bus.csr_wr, pipe_stall, flush, pc_redirect, trap_active, redirect_pc, trap_cause},
        64'h0);
    chk("reset_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 0;

    foreach (vecs[i]) begin
      pipe_write(32'h300, vecs[i].ms);
      pipe_write(32'h304, vecs[i].mie);
      if (vecs[i].take)
        run_trap(vecs[i].pc, vecs[i].ext, vecs[i].tim, vecs[i].exp_ms, vecs[i].cause, 1'b0, 1'b0);
      else
        no_take(vecs[i].ext, vecs[i].tim, $sformatf("vec%0d_masked", i));
    end

    // After entry MIE=0, so a pending enabled irq must not re-trap.
    no_take(1'b1, 1'b0, "no_nest");

    // mret: mstatus 0x80 -> 0x88, return to mepc 0x44.
    pipe_write(32'h300, 32'h80);
    pipe_write(32'h341, 32'h44);
    @(posedge clk); #1;
    inst_valid = 1; is_mret = 1; pc_in = 32'h90;
    exp_q.push_back({32'h300, 32'h88});
    redir_q.push_back(32'h44);
    @(negedge clk);
    chk("mret_detect_stall", pipe_stall, 1'b1);
    chk("mret_detect_no_wr", csr_bus.csr_wr, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("mret_stall_k%0d", k), pipe_stall, (k < 3));
      chk($sformatf("mret_redir_k%0d", k), pc_redirect, (k == 2));
      @(posedge clk); #1;
    end
    chk("mret_mstatus", m_mstatus, 32'h88);

    // Take collides with a pipeline write to mie: write dropped, pc to mepc.
    pipe_write(32'h300, 32'h8);
    pipe_write(32'h304, 32'h800);
    run_trap(32'h64, 1'b1, 1'b0, 32'h80, 32'h8000_000B, 1'b1, 1'b0);
    chk("collide_mie_kept", m_mie, 32'h800);

    // Take and mret together: interrupt wins, mepc is the mret's pc.
    pipe_write(32'h300, 32'h8);
    run_trap(32'h60, 1'b1, 1'b0, 32'h80, 32'h8000_000B, 1'b0, 1'b1);

    // Reset during SET_STATUS aborts without mstatus write or redirect.
    pipe_write(32'h300, 32'h8);
    @(posedge clk); #1;
    inst_valid = 1; pc_in = 32'h80; ext_irq = 1;
    exp_q.push_back({32'h341, 32'h80});
    @(negedge clk);
    chk("rst_seq_detect", pipe_stall, 1'b1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("rst_seq_save_state", dbg_state, ST_SAVE_EPC);
    @(posedge clk); #1;
    chk("rst_seq_in_set_status", dbg_state, ST_SET_STATUS);
    rst = 1;
    #1;
    chk("rst_mid_outputs",
        {csr_bus.csr_wr, pipe_stall, flush, pc_redirect, trap_active, redirect_pc, trap_cause},
        64'h0);
    chk("rst_mid_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mepc_kept", m_mepc, 32'h80);
    chk("rst_mstatus_kept", m_mstatus, 32'h8);
    chk("rst_idle_after", trap_active, 1'b0);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("redir_q_drained", redir_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
